// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - iterative radix-2 restoring single-precision divider
//
// Purpose: y = x1 / x2 in the reduced float format shared with fmul
//   (e=0 is zero, e=255 is infinity, no NaN/denormals, truncating).
//   One quotient bit per cycle, fixed 26-edge latency from acceptance to done.
// Ports:
//   clk    in   1   clock, posedge
//   rstn   in   1   asynchronous active-low reset
//   start  in   1   request, sampled only while ready=1
//   x1     in   32  dividend, sampled with start
//   x2     in   32  divisor, sampled with start
//   ready  out  1   FSM idle
//   done   out  1   one-cycle pulse, y valid
//   y      out  32  result, held until the next result
module fdiv_seq #(
  parameter int QBITS = 25
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        ready,
  output logic        done,
  output logic [31:0] y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(QBITS - 1);

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [QBITS-1:0]   r_q, r_d;
  logic [QBITS-1:0]   q_q, q_d;
  logic [23:0]        mb_q, mb_d;
  logic [7:0]         e1_q, e1_d;
  logic [7:0]         e2_q, e2_d;
  logic               sign_q, sign_d;
  logic               zero_q, zero_d;
  logic               inf_q, inf_d;
  logic [31:0]        y_q, y_d;
  logic               done_q, done_d;

  logic               ge;
  logic [QBITS-1:0]   r_sub;
  logic signed [9:0]  eraw;
  logic [22:0]        m;
  logic [31:0]        y_fin;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (cnt_q == CNT_LAST) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready = (state_q == S_IDLE);
  end

  assign done = done_q;
  assign y    = y_q;

  // Restoring step: remainder stays below 2*mb, so the shifted value fits QBITS bits.
  always_comb begin
    ge    = (r_q >= {1'b0, mb_q});
    r_sub = ge ? (r_q - {1'b0, mb_q}) : r_q;
  end

  // Normalisation and range check on the finished quotient
  always_comb begin
    if (q_q[QBITS-1]) begin
      m    = q_q[23:1];
      eraw = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd127;
    end else begin
      m    = q_q[22:0];
      eraw = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 10'sd126;
    end

    if (zero_q) begin
      y_fin = {sign_q, 8'h00, 23'h0};
    end else if (inf_q) begin
      y_fin = {sign_q, 8'hFF, 23'h0};
    end else if (eraw <= 10'sd0) begin
      y_fin = {sign_q, 8'h00, 23'h0};
    end else if (eraw >= 10'sd255) begin
      y_fin = {sign_q, 8'hFF, 23'h0};
    end else begin
      y_fin = {sign_q, eraw[7:0], m};
    end
  end

  // Datapath next values
  always_comb begin
    cnt_d  = cnt_q;
    r_d    = r_q;
    q_d    = q_q;
    mb_d   = mb_q;
    e1_d   = e1_q;
    e2_d   = e2_q;
    sign_d = sign_q;
    zero_d = zero_q;
    inf_d  = inf_q;
    y_d    = y_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d = x1[31] ^ x2[31];
          e1_d   = x1[30:23];
          e2_d   = x2[30:23];
          r_d    = {1'b0, 1'b1, x1[22:0]};
          mb_d   = {1'b1, x2[22:0]};
          q_d    = '0;
          cnt_d  = 5'd0;
          // Zero outranks infinity so 0/0 and inf/inf both yield zero
          zero_d = (x1[30:23] == 8'h00) || (x2[30:23] == 8'hFF);
          inf_d  = (x2[30:23] == 8'h00) || (x1[30:23] == 8'hFF);
        end
      end
      S_CALC: begin
        q_d   = {q_q[QBITS-2:0], ge};
        r_d   = {r_sub[QBITS-2:0], 1'b0};
        cnt_d = (cnt_q == CNT_LAST) ? 5'd0 : cnt_q + 5'd1;
      end
      S_FIN: begin
        y_d    = y_fin;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      r_q    <= '0;
      q_q    <= '0;
      mb_q   <= '0;
      e1_q   <= '0;
      e2_q   <= '0;
      sign_q <= 1'b0;
      zero_q <= 1'b0;
      inf_q  <= 1'b0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      r_q    <= r_d;
      q_q    <= q_d;
      mb_q   <= mb_d;
      e1_q   <= e1_d;
      e2_q   <= e2_d;
      sign_q <= sign_d;
      zero_q <= zero_d;
      inf_q  <= inf_d;
      y_q    <= y_d;
      done_q <= done_d;
    end
  end

endmodule
